dispatch_queue: RTL and testbench

- Consumer end of the decode→issue handshake: accepts C::di_t entries from the dynamic decoder (valid/ready) and buffers them in order in a circular FIFO.
- Presents the head entry to issue.
- Intercepts faulted entries at the head: they are never issued but reported to commit/trap logic, then the queue is cleared on acknowledge.
- Checks that incoming instruction ids are consecutive and flags any sequence error.

---
 rtl/dispatch_queue.sv | 124 ++++++++++++
 tb/tb_dispatch_queue.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_queue.sv
// Decode-to-issue dispatch queue: in-order circular FIFO with faulted-head
// interception and instruction id sequence checking.
package C;
  typedef logic [7:0] id_t;
  typedef struct packed {
    logic        valid;
    logic [31:0] si;
    id_t         id;
    logic        fault;
  } di_t;
endpackage

module dispatch_queue #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [$bits(C::di_t)-1:0] di_i,
  input  logic                     di_i_valid,
  output logic                     di_i_ready,
  input  logic                     flush_i,
  output logic [$bits(C::di_t)-1:0] issue_o,
  output logic                     issue_valid_o,
  input  logic                     issue_ready_i,
  output logic                     fault_o,
  output logic [$bits(C::id_t)-1:0] fault_id_o,
  input  logic                     fault_ack_i,
  output logic [PTR_W:0]           count_o,
  output logic                     seq_err_o
);

  typedef enum logic {RUN, FAULT} state_t;

  localparam logic [PTR_W:0] FULL = DEPTH[PTR_W:0];

  state_t           state_q, state_d;
  C::di_t           mem [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [PTR_W:0]   count_q;
  logic             resync_q;
  C::id_t           next_id_q;
  logic             seq_err_q;
  C::id_t           fault_id_q;
  C::di_t           din, head;
  logic             head_valid, push, pop, clear;

  assign din        = di_i;
  assign head       = mem[rptr_q];
  assign head_valid = (count_q != '0);

  always_comb begin
    state_d       = state_q;
    di_i_ready    = 1'b0;
    issue_valid_o = 1'b0;
    clear         = 1'b0;
    unique case (state_q)
      RUN: begin
        di_i_ready    = (count_q < FULL) && !flush_i;
        issue_valid_o = head_valid && !head.fault && !flush_i;
        if (head_valid && head.fault) state_d = FAULT;
      end
      FAULT: begin
        if (fault_ack_i) begin
          clear   = 1'b1;
          state_d = RUN;
        end
      end
    endcase
    // Flush overrides everything, including a concurrent fault acknowledge.
    if (flush_i) begin
      clear   = 1'b1;
      state_d = RUN;
    end
  end

  assign push = di_i_valid && di_i_ready;
  assign pop  = issue_valid_o && issue_ready_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= RUN;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      resync_q   <= 1'b1;
      next_id_q  <= '0;
      seq_err_q  <= 1'b0;
      fault_id_q <= '0;
    end else begin
      state_q <= state_d;
      if (clear) begin
        wptr_q     <= '0;
        rptr_q     <= '0;
        count_q    <= '0;
        resync_q   <= 1'b1;
        fault_id_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + 1'b1;
        if (pop)  rptr_q <= rptr_q + 1'b1;
        if (push && !pop)      count_q <= count_q + 1'b1;
        else if (pop && !push) count_q <= count_q - 1'b1;
        if (push) begin
          if (!resync_q && (din.id != next_id_q)) seq_err_q <= 1'b1;
          next_id_q <= din.id + 1'b1;
          resync_q  <= 1'b0;
        end
        // Head cannot move while faulted, so its id is captured once on entry.
        if (state_q == RUN && state_d == FAULT) fault_id_q <= head.id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= din;
  end

  assign issue_o    = head_valid ? head : '0;
  assign fault_o    = (state_q == FAULT);
  assign fault_id_o = fault_id_q;
  assign count_o    = count_q;
  assign seq_err_o  = seq_err_q;

endmodule

// File: tb/tb_dispatch_queue.sv
// Bench for dispatch_queue: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dispatch_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = $bits(C::di_t);

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] di_i = '0;
  logic          di_i_valid = 1'b0;
  logic          di_i_ready;
  logic          flush_i = 1'b0;
  logic [DW-1:0] issue_o;
  logic          issue_valid_o;
  logic          issue_ready_i = 1'b0;
  logic          fault_o;
  logic [7:0]    fault_id_o;
  logic          fault_ack_i = 1'b0;
  logic [2:0]    count_o;
  logic          seq_err_o;

  dispatch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .di_i(di_i), .di_i_valid(di_i_valid),
    .di_i_ready(di_i_ready), .flush_i(flush_i), .issue_o(issue_o),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .fault_o(fault_o), .fault_id_o(fault_id_o), .fault_ack_i(fault_ack_i),
    .count_o(count_o), .seq_err_o(seq_err_o)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Reference model: the queue contents themselves plus a few flags.
  C::di_t mq[$];
  bit     m_fault  = 1'b0;
  C::id_t m_fid    = '0;
  bit     m_seq    = 1'b0;
  bit     m_resync = 1'b1;
  C::id_t m_next   = '0;

  function automatic bit m_ready();
    return (mq.size() < DEPTH) && !m_fault && !flush_i;
  endfunction

  function automatic bit m_ivalid();
    return !m_fault && (mq.size() > 0) && !mq[0].fault && !flush_i;
  endfunction

  always @(posedge clk or negedge rstn) begin
    bit     do_push, do_pop;
    C::di_t d;
    if (!rstn) begin
      mq.delete();
      m_fault = 1'b0; m_fid = '0; m_seq = 1'b0; m_resync = 1'b1; m_next = '0;
    end else begin
      d       = di_i;
      do_push = di_i_valid && m_ready();
      do_pop  = issue_ready_i && m_ivalid();
      if (flush_i || (m_fault && fault_ack_i)) begin
        mq.delete();
        m_fault = 1'b0; m_fid = '0; m_resync = 1'b1;
      end else if (!m_fault) begin
        if (mq.size() > 0 && mq[0].fault) begin
          m_fault = 1'b1;
          m_fid   = mq[0].id;
        end
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
          if (!m_resync && d.id != m_next) m_seq = 1'b1;
          m_next   = d.id + 8'd1;
          m_resync = 1'b0;
          mq.push_back(d);
        end
      end
    end
  end

  always @(negedge clk) begin
    C::di_t exp_issue;
    exp_issue = '0;
    if (mq.size() > 0) exp_issue = mq[0];
    chk("di_i_ready", di_i_ready, m_ready());
    chk("issue_valid_o", issue_valid_o, m_ivalid());
    chk("issue_o", issue_o, exp_issue);
    chk("fault_o", fault_o, m_fault);
    chk("fault_id_o", fault_id_o, m_fault ? m_fid : 8'd0);
    chk("count_o", count_o, mq.size());
    chk("seq_err_o", seq_err_o, m_seq);
  end

  function automatic C::id_t head_id();
    C::di_t h;
    h = issue_o;
    return h.id;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input C::id_t id, input bit f);
    C::di_t d;
    d.valid = 1'($urandom);
    d.si    = $urandom;
    d.id    = id;
    d.fault = f;
    di_i    = d;
  endtask

  task automatic push(input C::id_t id, input bit f);
    drive(id, f);
    di_i_valid = 1'b1;
    tick();
    di_i_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, di_i_ready, 1'b1);
    chk({tag, "_ivalid"}, issue_valid_o, 1'b0);
    chk({tag, "_fault"}, fault_o, 1'b0);
    chk({tag, "_fid"}, fault_id_o, 8'd0);
    chk({tag, "_count"}, count_o, 3'd0);
    chk({tag, "_issue"}, issue_o, '0);
    chk({tag, "_seq"}, seq_err_o, 1'b0);
  endtask

  initial begin
    repeat (3) tick();
    #3 chk_reset_outputs("rst");
    tick();
    rstn = 1'b1;

    // In-order issue of 5,6,7 once issue becomes ready.
    push(8'd5, 1'b0); push(8'd6, 1'b0); push(8'd7, 1'b0);
    chk("t1_count3", count_o, 3'd3);
    issue_ready_i = 1'b1;
    #3 chk("t1_id5", head_id(), 8'd5); chk("t1_v5", issue_valid_o, 1'b1);
    tick(); #3 chk("t1_id6", head_id(), 8'd6);
    tick(); #3 chk("t1_id7", head_id(), 8'd7);
    tick(); issue_ready_i = 1'b0;
    #3 chk("t1_count0", count_o, 3'd0); chk("t1_seq", seq_err_o, 1'b0);

    // Fill, blocked pop+push while full, then wrap the pointers.
    tick();
    for (int i = 0; i < 4; i++) push(C::id_t'(8 + i), 1'b0);
    #3 chk("t2_full_ready", di_i_ready, 1'b0); chk("t2_count4", count_o, 3'd4);
    tick();
    drive(8'd12, 1'b0);
    di_i_valid = 1'b1; issue_ready_i = 1'b1;
    #3 chk("t2_full_block", di_i_ready, 1'b0);
    tick();
    di_i_valid = 1'b0; issue_ready_i = 1'b0;
    #3 chk("t2_count3", count_o, 3'd3); chk("t2_ready_again", di_i_ready, 1'b1);
    tick();
    di_i_valid = 1'b1; issue_ready_i = 1'b1;
    for (int k = 0; k < 16; k++) begin
      drive(C::id_t'(12 + k), 1'b0);
      #3 chk("t2_wrap_head", head_id(), C::id_t'(9 + k));
      chk("t2_wrap_count", count_o, 3'd3);
      tick();
    end
    di_i_valid = 1'b0;
    repeat (3) tick();
    issue_ready_i = 1'b0;
    chk("t2_drained", count_o, 3'd0);

    // Faulted entry in the middle: 10 issues, 11 traps, 12 never issues.
    flush_i = 1'b1; tick(); flush_i = 1'b0;
    push(8'd10, 1'b0); push(8'd11, 1'b1); push(8'd12, 1'b0);
    issue_ready_i = 1'b1;
    #3 chk("t3_id10", head_id(), 8'd10); chk("t3_v10", issue_valid_o, 1'b1);
    tick(); #3 chk("t3_no_issue11", issue_valid_o, 1'b0);
    tick();
    #3 chk("t3_fault", fault_o, 1'b1); chk("t3_fid", fault_id_o, 8'd11);
    chk("t3_ivalid", issue_valid_o, 1'b0); chk("t3_ready", di_i_ready, 1'b0);
    chk("t3_count", count_o, 3'd2);
    fault_ack_i = 1'b1;
    tick();
    fault_ack_i = 1'b0; issue_ready_i = 1'b0;
    #3 chk("t3_ack_count", count_o, 3'd0); chk("t3_ack_fault", fault_o, 1'b0);
    chk("t3_ack_ready", di_i_ready, 1'b1);
    tick();

    // Sequence error is sticky across flush; resync after flush.
    push(8'd3, 1'b0); push(8'd5, 1'b0);
    #3 chk("t4_seq_set", seq_err_o, 1'b1);
    flush_i = 1'b1; tick(); flush_i = 1'b0;
    #3 chk("t4_seq_flush", seq_err_o, 1'b1); chk("t4_flush_count", count_o, 3'd0);
    tick();
    push(8'd40, 1'b0);
    #3 chk("t4_seq_resync", seq_err_o, 1'b1);
    tick();

    // Flush beats concurrent push and pop.
    push(8'd41, 1'b0); push(8'd42, 1'b0);
    chk("t5_count3", count_o, 3'd3);
    drive(8'd43, 1'b0);
    flush_i = 1'b1; di_i_valid = 1'b1; issue_ready_i = 1'b1;
    #1 chk("t5_ready", di_i_ready, 1'b0); chk("t5_ivalid", issue_valid_o, 1'b0);
    tick();
    flush_i = 1'b0; di_i_valid = 1'b0; issue_ready_i = 1'b0;
    #3 chk("t5_count0", count_o, 3'd0);
    tick();

    // Asynchronous reset while faulted with two entries.
    push(8'd50, 1'b1); push(8'd51, 1'b0);
    #3 chk("t6_fault", fault_o, 1'b1); chk("t6_count2", count_o, 3'd2);
    rstn = 1'b0;
    #1 chk_reset_outputs("t6_async");
    tick(); tick();
    rstn = 1'b1;
    push(8'd0, 1'b0);
    #3 chk("t6_v0", issue_valid_o, 1'b1); chk("t6_id0", head_id(), 8'd0);
    issue_ready_i = 1'b1;
    tick();
    issue_ready_i = 1'b0;
    #3 chk("t6_count0", count_o, 3'd0);
    tick();

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      C::di_t d;
      d.valid = 1'($urandom);
      d.si    = $urandom;
      d.fault = ($urandom_range(0, 19) == 0);
      d.id    = ($urandom_range(0, 29) == 0) ? C::id_t'($urandom) : m_next;
      di_i          = d;
      di_i_valid    = ($urandom_range(0, 9) < 6);
      issue_ready_i = ($urandom_range(0, 9) < 6);
      flush_i       = ($urandom_range(0, 49) == 0);
      fault_ack_i   = ($urandom_range(0, 3) == 0);
      tick();
    end
    di_i_valid = 1'b0; issue_ready_i = 1'b0; flush_i = 1'b0; fault_ack_i = 1'b0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
